// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types, constants and the circular winner search for
//               the N-to-1 sram-like arbiter.
//               Contents: MAX_MST (upper bound on master count), mst_id_t
//               (master index type), rr_pick() (first requester at or after
//               a start index, searching circularly).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int MAX_MST = 8;

    typedef logic [2:0] mst_id_t;

    // The request vector is zero-padded to MAX_MST bits by the caller. Padded
    // positions never request, so a circular walk over all MAX_MST slots
    // visits the real masters in the same order as a walk over N_MST slots.
    // When nothing requests, ptr is returned; callers gate by the request bit.
    function automatic mst_id_t rr_pick(input logic [MAX_MST-1:0] req,
                                        input mst_id_t            ptr);
        mst_id_t idx;
        logic    found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_MST; k++) begin
            idx = ptr + k[2:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_id_fifo
// Description : In-order FIFO holding the master index of every accepted
//               request, so each data_ok can be routed back to its issuer.
//               Ports: clk, resetn (sync, active-low), push/din (write),
//               pop/dout (read head, dout valid while !empty), full, empty.
//               Push while full and pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           PW      = $clog2(DEPTH);
    localparam logic [PW:0]  PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign full   = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                    (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_arb_nx1.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arb_nx1
// Description : Zero-latency N-to-1 arbiter merging sram-like masters onto a
//               single sram-like slave. A pending (not yet accepted) request
//               locks the grant so the slave sees a stable request until
//               addr_ok. Accepted master indices are queued so data_ok is
//               returned to the issuing master in order.
//               Master side: m_req/m_wr/m_size/m_addr/m_wdata (packed per
//               master), m_addr_ok/m_data_ok (one-hot), m_rdata (broadcast).
//               Slave side : s_req/s_wr/s_size/s_addr/s_wdata out,
//               s_rdata/s_addr_ok/s_data_ok in.
//               Build option: SRAM_ARB_RR_EN selects round-robin arbitration;
//               without it the lowest requesting index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arb_nx1
    import sram_arb_pkg::*;
#(
    parameter int N_MST = 2,
    parameter int OUTST = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N_MST-1:0]    m_req,
    input  logic [N_MST-1:0]    m_wr,
    input  logic [2*N_MST-1:0]  m_size,
    input  logic [AW*N_MST-1:0] m_addr,
    input  logic [DW*N_MST-1:0] m_wdata,
    output logic [DW-1:0]       m_rdata,
    output logic [N_MST-1:0]    m_addr_ok,
    output logic [N_MST-1:0]    m_data_ok,
    output logic                s_req,
    output logic                s_wr,
    output logic [1:0]          s_size,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wdata,
    input  logic [DW-1:0]       s_rdata,
    input  logic                s_addr_ok,
    input  logic                s_data_ok
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
    localparam mst_id_t    LAST_MST    = mst_id_t'(N_MST - 1);

    logic [0:0]         state_q, state_d;
    mst_id_t            lock_id_q, lock_id_d;
    logic [MAX_MST-1:0] w_req_pad;
    mst_id_t            w_pick;
    mst_id_t            w_grant;
    logic               w_grant_req;
    logic               w_hs;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    mst_id_t            w_head;

    always_comb begin
        w_req_pad              = '0;
        w_req_pad[N_MST-1:0]   = m_req;
    end

`ifdef SRAM_ARB_RR_EN
    mst_id_t rr_ptr_q, rr_ptr_d;

    assign w_pick = rr_pick(w_req_pad, rr_ptr_q);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_hs) rr_ptr_d = (w_grant == LAST_MST) ? '0 : w_grant + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`else
    // Starting the circular search at 0 gives plain lowest-index priority.
    assign w_pick = rr_pick(w_req_pad, '0);
`endif

    assign w_grant     = (state_q == ST_LOCKED) ? lock_id_q : w_pick;
    assign w_grant_req = w_req_pad[w_grant];
    assign s_req       = w_grant_req & ~w_full;
    assign w_hs        = s_req & s_addr_ok;
    assign w_pop       = s_data_ok & ~w_empty;
    assign m_rdata     = s_rdata;

    // Request payload mux; everything reads zero when the granted master
    // is not requesting.
    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (w_grant_req && (w_grant == mst_id_t'(i))) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_addr  = m_addr[AW*i +: AW];
                s_wdata = m_wdata[DW*i +: DW];
            end
        end
    end

    // Handshake indicators are held low while reset is asserted.
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < N_MST; i++) begin
            m_addr_ok[i] = resetn & w_hs  & (w_grant == mst_id_t'(i));
            m_data_ok[i] = resetn & w_pop & (w_head  == mst_id_t'(i));
        end
    end

    // A request the slave has not yet accepted pins the grant to its master.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (s_req && !s_addr_ok) begin
                    state_d   = ST_LOCKED;
                    lock_id_d = w_grant;
                end
            end
            ST_LOCKED: begin
                if (w_hs) state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_UNLOCKED;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    sram_arb_id_fifo #(
        .DEPTH (OUTST),
        .WIDTH ($bits(mst_id_t))
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_hs),
        .pop    (s_data_ok),
        .din    (w_grant),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arb_nx1.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_arb_nx1
// Description : Directed self-checking bench for sram_like_arb_nx1 with
//               N_MST=4, OUTST=4. Expected grants follow the build option
//               SRAM_ARB_RR_EN (round-robin) or fixed priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_arb_nx1;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_wr;
    logic [2*N-1:0]    m_size;
    logic [AW*N-1:0]   m_addr;
    logic [DW*N-1:0]   m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_addr_ok;
    logic [N-1:0]      m_data_ok;
    logic              s_req;
    logic              s_wr;
    logic [1:0]        s_size;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW-1:0]     s_rdata;
    logic              s_addr_ok;
    logic              s_data_ok;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_like_arb_nx1 #(
        .N_MST (N),
        .OUTST (4),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .s_req     (s_req),
        .s_wr      (s_wr),
        .s_size    (s_size),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs settle before checks.
    task automatic drive(input logic [N-1:0] req, input logic aok, input logic dok);
        m_req     = req;
        s_addr_ok = aok;
        s_data_ok = dok;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1000_0000 + 32'h100 * i;
    endfunction

    initial begin
        resetn    = 1'b0;
        m_req     = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = 32'hCAFE_0000;
        for (int i = 0; i < N; i++) begin
            m_wr[i]              = i[0];
            m_size[2*i +: 2]     = i[1:0];
            m_addr[AW*i +: AW]   = addr_of(i);
            m_wdata[DW*i +: DW]  = 32'hD000_0000 + i;
        end

        // ---- reset: handshake strobes held low ----
        #1;
        drive(4'b0000, 1'b1, 1'b1);
        check("rst_addr_ok", m_addr_ok, 4'b0000);
        check("rst_data_ok", m_data_ok, 4'b0000);
        check("rst_s_req",   s_req,     1'b0);
        tick(); tick();
        resetn = 1'b1;

        // ---- priority, req=1010 ----
        drive(4'b1010, 1'b1, 1'b0);
        check("pri_a_addr_ok", m_addr_ok, 4'b0010);
        check("pri_a_s_addr",  s_addr,    addr_of(1));
        check("pri_a_s_wr",    s_wr,      1'b1);
        check("pri_a_s_size",  s_size,    2'd1);
        check("pri_a_s_wdata", s_wdata,   32'hD000_0001);
        tick();
        drive(4'b1010, 1'b1, 1'b0);
        check("pri_b_addr_ok", m_addr_ok, RR ? 4'b1000 : 4'b0010);
        tick();
        s_rdata = 32'h1234_5678;
        drive(4'b0000, 1'b0, 1'b1);
        check("ret_a_data_ok", m_data_ok, 4'b0010);
        check("ret_a_rdata",   m_rdata,   32'h1234_5678);
        check("idle_s_req",    s_req,     1'b0);
        check("idle_s_addr",   s_addr,    32'h0);
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        check("ret_b_data_ok", m_data_ok, RR ? 4'b1000 : 4'b0010);
        tick();

        // ---- data_ok with empty FIFO is dropped ----
        drive(4'b0000, 1'b0, 1'b1);
        check("empty_data_ok", m_data_ok, 4'b0000);
        tick();

        // ---- lock: master 1 pending, master 0 joins ----
        drive(4'b0010, 1'b0, 1'b0);
        check("lock1_s_req",   s_req,     1'b1);
        check("lock1_s_addr",  s_addr,    addr_of(1));
        check("lock1_addr_ok", m_addr_ok, 4'b0000);
        tick();
        drive(4'b0011, 1'b0, 1'b0);
        check("lock2_s_addr",  s_addr,    addr_of(1));
        tick();
        drive(4'b0011, 1'b1, 1'b0);
        check("lock3_addr_ok", m_addr_ok, 4'b0010);
        tick();
        drive(4'b0001, 1'b1, 1'b0);
        check("lock4_addr_ok", m_addr_ok, 4'b0001);
        check("lock4_s_addr",  s_addr,    addr_of(0));
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        check("lock_ret1", m_data_ok, 4'b0010);
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        check("lock_ret0", m_data_ok, 4'b0001);
        tick();

        // ---- FIFO full stall ----
        for (int k = 0; k < 4; k++) begin
            drive(4'b0100, 1'b1, 1'b0);
            check($sformatf("fill%0d_addr_ok", k), m_addr_ok, 4'b0100);
            tick();
        end
        drive(4'b0100, 1'b1, 1'b0);
        check("full_s_req",   s_req,     1'b0);
        check("full_addr_ok", m_addr_ok, 4'b0000);
        tick();
        drive(4'b0100, 1'b1, 1'b1);
        check("fullpop_s_req",   s_req,     1'b0);
        check("fullpop_addr_ok", m_addr_ok, 4'b0000);
        check("fullpop_data_ok", m_data_ok, 4'b0100);
        tick();
        drive(4'b0100, 1'b1, 1'b0);
        check("after_pop_s_req",   s_req,     1'b1);
        check("after_pop_addr_ok", m_addr_ok, 4'b0100);
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        check("pre_rst_data_ok", m_data_ok, 4'b0100);
        tick();

        // ---- reset with 3 outstanding ----
        resetn = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        check("midrst_data_ok", m_data_ok, 4'b0000);
        tick();
        resetn = 1'b1;
        drive(4'b0000, 1'b0, 1'b1);
        check("postrst_data_ok", m_data_ok, 4'b0000);
        tick();
        drive(4'b1000, 1'b1, 1'b0);
        check("postrst_addr_ok", m_addr_ok, 4'b1000);
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        check("postrst_head", m_data_ok, 4'b1000);
        tick();

        // ---- back-to-back with one-cycle data return ----
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 1'b1, (k > 0));
            check($sformatf("b2b%0d_addr_ok", k), m_addr_ok,
                  RR ? (4'b0001 << k) : 4'b0001);
            if (k > 0)
                check($sformatf("b2b%0d_data_ok", k), m_data_ok,
                      RR ? (4'b0001 << (k - 1)) : 4'b0001);
            tick();
        end
        drive(4'b0000, 1'b0, 1'b1);
        check("b2b_last_data_ok", m_data_ok, RR ? 4'b1000 : 4'b0001);
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        check("b2b_drained", m_data_ok, 4'b0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_like_arb_nx1.md
# sram_like_arb_nx1

Parametrised N-to-1 sram-like arbiter that merges several sram-like masters (e.g. uncached data path, cache refill/writeback, future TLB walker) onto one sram-like slave port in front of `cpu_axi_interface`. It replaces fixed two-way merging with a configurable master count, a lockable grant and an in-order outstanding-transaction ID FIFO. The ID FIFO routes each `data_ok` back to the master that issued the matching request. The arbiter adds zero cycles of latency.

## Interface
Parameters:
- `N_MST`, 2: number of masters, 2..8.
- `OUTST`, 4: maximum outstanding transactions; ID FIFO depth, power of two, ≥2.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: synchronous reset, active-low.
- `m_req` in N_MST: per-master request.
- `m_wr` in N_MST: per-master write flag.
- `m_size` in 2·N_MST: per-master size, master i at bits [2i+1:2i].
- `m_addr` in AW·N_MST: per-master address, packed the same way.
- `m_wdata` in DW·N_MST: per-master write data.
- `m_rdata` out DW: read data, broadcast to all masters.
- `m_addr_ok` out N_MST: per-master address accept.
- `m_data_ok` out N_MST: per-master data return.
- `s_req`, `s_wr`, `s_size`[2], `s_addr`[AW], `s_wdata`[DW] out: slave request channel.
- `s_rdata` in DW: slave read data.
- `s_addr_ok` in 1: slave address accept.
- `s_data_ok` in 1: slave data return.

## Operation
- Address handshake: `s_req & s_addr_ok`.
- Grant:
  - If `lock_vld`, the grant is `lock_id`.
  - Otherwise the grant is the arbitration winner among masters with `m_req` set.
- Slave request drive:
  - `s_req = m_req[g] & ~fifo_full`.
  - `s_wr`, `s_size`, `s_addr` and `s_wdata` are muxed from master g.
  - With no request, all slave outputs are 0.
- Address accept: `m_addr_ok[g] = s_addr_ok & s_req`. All other bits of `m_addr_ok` are 0.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED→LOCKED when `s_req & ~s_addr_ok`. Latch `lock_id = g`.
  - LOCKED→UNLOCKED on the address handshake.
  - The lock keeps the sram-like rule that a request is held stable until `addr_ok`.
- ID FIFO:
  - On each address handshake, push g.
  - On each `s_data_ok`, pop the head.
  - `m_data_ok[head] = s_data_ok & ~fifo_empty`. All other bits of `m_data_ok` are 0.
  - `m_rdata = s_rdata`, unconditionally.
- Full FIFO: `s_req` is forced to 0, so no master can receive `addr_ok`. This applies even if a pop happens in the same cycle; the push stall clears on the next cycle.
- Empty FIFO with `s_data_ok`: protocol error. The beat is dropped and no `m_data_ok` is raised. The FIFO pointers do not change.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointer wrap: `rd_ptr` and `wr_ptr` are $clog2(OUTST) bits wide plus one wrap bit.
  - full = addresses equal and wrap bits differ.
  - empty = pointers fully equal.

## Timing
- Request path m→s, `addr_ok` path s→m and `data_ok` path s→m are combinational; there is no added latency.
- Round-robin pointer `rr_ptr` updates on each address handshake, the cycle after, to `(g+1) mod N_MST`.
- Register reset values when `resetn=0` at the clock edge: `rr_ptr=0`, `lock_vld=0`, `lock_id=0`, FIFO empty, both pointers 0.
- Output values during reset:
  - `m_addr_ok=0`, `m_data_ok=0`.
  - `s_req` follows `m_req` from the reset register state, so the driving logic must hold requests low while in reset.
- Reset mid-transaction: all outstanding IDs are discarded. Any later `s_data_ok` falls under the empty-FIFO rule.
- Back-to-back: one address handshake per cycle is sustained while the FIFO is not full.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - Winner is the first requesting master at or after `rr_ptr`, searching circularly.
- `SRAM_ARB_RR_EN` undefined: fixed priority.
  - Lowest index wins.
  - `rr_ptr` is not implemented.
- Lock and FIFO behaviour are identical in both builds.

## Structure
- Package `sram_arb_pkg`:
  - constant for the max `N_MST` (8);
  - typedef `mst_id_t` (logic [2:0]);
  - function `rr_pick(req, ptr)` returning the winner index.
- Sub-module `sram_arb_id_fifo`:
  - parametrised on depth and width;
  - ports: push, pop, din, dout, full, empty.
- Top level: arbitration, lock state machine and muxing, roughly 200 lines.

## Test plan
- N_MST=2, RR build, both masters request every cycle, slave `addr_ok=1` and `data_ok` one cycle later → grants alternate 0,1,0,1. Each `m_data_ok` bit fires for its own master in issue order.
- Master 1 requests with slave `addr_ok` held low 3 cycles while master 0 raises req in cycle 2 → grant stays 1 until the handshake in cycle 3, then goes to 0.
- OUTST=4, 4 handshakes with no `data_ok` → `s_req=0` and `m_addr_ok=0` on the 5th request. One `data_ok` pops ID of master of first request; 5th is accepted the following cycle.
- Fixed-priority build, N_MST=4, req=4'b1010 → master 1 granted. After its handshake with req still 4'b1010, master 1 is granted again.
- `s_data_ok` pulsed with FIFO empty → all `m_data_ok=0` and FIFO remains empty.
- `resetn` low for one cycle with 3 outstanding transactions → FIFO empty. The next `s_data_ok` produces no `m_data_ok`.
